// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.
// Hits are served combinationally; misses stall the pipeline while the line is written back and refilled.
module dcache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              dcache_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - 2 - WOFF_W - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WB     = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;

    logic [1:0]        state;
    logic [WOFF_W-1:0] beat;
    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

    logic [WOFF_W-1:0] req_woff;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_bits;
    logic              hit;
    logic              last_beat;
    logic              store_hit;
    logic              refill_beat;
    logic              refill_done;

    assign req_woff    = req_addr[2 +: WOFF_W];
    assign idx         = req_addr[2+WOFF_W +: IDX_W];
    assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
    assign unused_bits = ^req_addr[1:0];

    assign hit         = valid[idx] && (tag_q[idx] == req_tag);
    assign last_beat   = (beat == WOFF_W'(LINE_WORDS - 1));
    assign store_hit   = (state == S_IDLE) && req_valid && req_we && hit;
    assign refill_beat = (state == S_REFILL) && mem_ack;
    assign refill_done = refill_beat && last_beat;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            beat  <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (hit) begin
                            if (req_we) dirty[idx] <= 1'b1;
                        end else begin
                            // The line is invalidated up front so a refill cut short by reset never hits.
                            beat       <= '0;
                            valid[idx] <= 1'b0;
                            state      <= (valid[idx] && dirty[idx]) ? S_WB : S_REFILL;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) begin
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (store_hit) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (req_wstrb[b]) data_q[idx][req_woff][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
            if (refill_beat) data_q[idx][beat] <= mem_rdata;
            if (refill_done) tag_q[idx] <= req_tag;
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        rdata        = '0;
        dcache_stall = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!rst) begin
            rdata = data_q[idx][req_woff];
            case (state)
                S_IDLE: dcache_stall = req_valid && !hit;
                S_WB: begin
                    dcache_stall = 1'b1;
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr     = {tag_q[idx], idx, beat, 2'b00};
                    mem_wdata    = data_q[idx][beat];
                end
                S_REFILL: begin
                    dcache_stall = 1'b1;
                    mem_req      = 1'b1;
                    mem_addr     = {req_tag, idx, beat, 2'b00};
                end
                default: dcache_stall = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of requests plus hand sequences,
// with a queue of expected memory beats checked by a memory responder.
module tb_dcache_ctrl;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic [31:0] wb_base;
        logic [31:0] rf_base;
        int          delay;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata;
    logic        dcache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int ack_cnt = 0;
    logic mem_init = 1'b1;

    logic [31:0] mem_model [0:1023];
    logic [31:0] golden    [0:1023];
    beat_t       beat_q [$];
    logic [31:0] rd_q   [$];
    vec_t        vecs   [13];

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rdata(rdata), .dcache_stall(dcache_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            32'h40:  return 32'h1111_1111;
            32'h41:  return 32'h2222_2222;
            32'h42:  return 32'h3333_3333;
            32'h43:  return 32'h4444_4444;
            default: return {16'h5A5A, 16'(i * 4)};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ack after ack_delay wait cycles, writebacks update the backing store.
    always_comb mem_ack = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_model[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem_model[i] <= init_word(i);
        end else if (mem_req && mem_ack && mem_we) begin
            mem_model[mem_addr[11:2]] <= mem_wdata;
        end
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
        if (mem_req && mem_ack) ack_cnt <= ack_cnt + 1;
    end

    // Every cycle with mem_req must match the head of the expected-beat queue, held until ack.
    always @(negedge clk) begin
        if (mem_req) begin
            if (beat_q.size() == 0) begin
                check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
            end else begin
                check("beat_we", {31'd0, mem_we}, {31'd0, beat_q[0].we});
                check("beat_addr", mem_addr, beat_q[0].addr);
                if (beat_q[0].we) check("beat_wdata", mem_wdata, beat_q[0].data);
                if (mem_ack) void'(beat_q.pop_front());
            end
        end
    end

    task automatic push_line(input logic we, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.we   = we;
            b.addr = base + 32'(4 * k);
            b.data = golden[base[11:2] + 10'(k)];
            beat_q.push_back(b);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that consumes the request.
    task automatic do_req(input vec_t v);
        int cnt;
        ack_delay = v.delay;
        if (v.wb_base != NONE) push_line(1'b1, v.wb_base);
        if (v.rf_base != NONE) push_line(1'b0, v.rf_base);
        if (!v.we) rd_q.push_back(v.exp_rdata);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        cnt = 0;
        @(negedge clk);
        while (dcache_stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("stall_cycles", cnt, v.exp_stall);
        if (!v.we) check("rdata", rdata, rd_q.pop_front());
        check("beats_left", beat_q.size(), 0);
        if (v.we) begin
            for (int b = 0; b < 4; b++)
                if (v.wstrb[b]) golden[v.addr[11:2]][8*b +: 8] = v.wdata[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   tgt;
        //                 we    addr          wdata         strb  exp_rdata     stall wb_base       rf_base       delay
        vecs[0]  = '{1'b0, 32'h100, 32'h0,         4'h0, 32'h1111_1111, 5,  NONE,    32'h100, 0};
        vecs[1]  = '{1'b0, 32'h108, 32'h0,         4'h0, 32'h3333_3333, 0,  NONE,    NONE,    0};
        vecs[2]  = '{1'b1, 32'h108, 32'hAAAA_BBBB, 4'h3, 32'h0,         0,  NONE,    NONE,    0};
        vecs[3]  = '{1'b0, 32'h108, 32'h0,         4'h0, 32'h3333_BBBB, 0,  NONE,    NONE,    0};
        vecs[4]  = '{1'b1, 32'h104, 32'hFFFF_FFFF, 4'h0, 32'h0,         0,  NONE,    NONE,    0};
        vecs[5]  = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h2222_2222, 0,  NONE,    NONE,    0};
        vecs[6]  = '{1'b0, 32'h500, 32'h0,         4'h0, 32'h5A5A_0500, 9,  32'h100, 32'h500, 0};
        vecs[7]  = '{1'b0, 32'h100, 32'h0,         4'h0, 32'h1111_1111, 5,  NONE,    32'h100, 0};
        vecs[8]  = '{1'b0, 32'h108, 32'h0,         4'h0, 32'h3333_BBBB, 0,  NONE,    NONE,    0};
        vecs[9]  = '{1'b1, 32'h50C, 32'hDEAD_BEEF, 4'hF, 32'h0,         17, NONE,    32'h500, 3};
        vecs[10] = '{1'b0, 32'h50C, 32'h0,         4'h0, 32'hDEAD_BEEF, 0,  NONE,    NONE,    3};
        vecs[11] = '{1'b0, 32'h100, 32'h0,         4'h0, 32'h1111_1111, 33, 32'h500, 32'h100, 3};
        vecs[12] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h2222_2222, 0,  NONE,    NONE,    0};

        for (int i = 0; i < 1024; i++) golden[i] = init_word(i);

        // Reset with a live request: outputs must be forced quiet.
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
        req_wdata = '0; req_wstrb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, dcache_stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, dcache_stall}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) do_req(vecs[i]);

        // Store hit repeated while the pipeline is held elsewhere.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10C;
        req_wdata = 32'h1234_5678; req_wstrb = 4'b1100;
        repeat (3) begin
            @(negedge clk);
            check("repeat_store_stall", {31'd0, dcache_stall}, 32'd0);
        end
        @(posedge clk); #1;
        v = '{1'b0, 32'h10C, 32'h0, 4'h0, 32'h1234_4444, 0, NONE, NONE, 0};
        do_req(v);

        // Reset asserted after the second refill ack of a cold miss.
        push_line(1'b0, 32'h200);
        tgt = ack_cnt + 2;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (ack_cnt == tgt) break;
        end
        check("rst_wait_acks", ack_cnt, tgt);
        rst = 1'b1; req_valid = 1'b0;
        beat_q.delete();
        #1;
        check("midrst_stall", {31'd0, dcache_stall}, 32'd0);
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_stall", {31'd0, dcache_stall}, 32'd0);
        check("postrst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        v = '{1'b0, 32'h200, 32'h0, 4'h0, 32'h5A5A_0200, 5, NONE, 32'h200, 0};
        do_req(v);
        v = '{1'b0, 32'h204, 32'h0, 4'h0, 32'h5A5A_0204, 0, NONE, NONE, 0};
        do_req(v);
        v = '{1'b0, 32'h100, 32'h0, 4'h0, 32'h1111_1111, 5, NONE, 32'h100, 0};
        do_req(v);

        req_valid = 1'b0;
        @(negedge clk);
        check("final_idle_stall", {31'd0, dcache_stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the MEM stage and main memory.
- Serves the MEM-stage load/store request combinationally on a hit.
- On a miss, raises dcache_stall, which freezes the pipeline registers upstream, while it writes back the victim line and refills the missing line over a word-per-beat memory handshake.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; fixed at 32 (byte strobe is 4 bits).
- LINE_WORDS, 4, words per line; power of 2, ≥2.
- SETS, 64, number of lines; power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  MEM stage issues a load or store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; word-aligned.
- req_wdata  in  DATA_W  store data.
- req_wstrb  in  4  store byte enables; bit i covers bits [8i+7:8i].
- rdata  out  DATA_W  load data; valid when req_valid & !req_we & !dcache_stall.
- dcache_stall  out  1  pipeline hold request.
- mem_req  out  1  memory beat request; held until mem_ack.
- mem_we  out  1  1 = writeback beat, 0 = refill beat.
- mem_addr  out  ADDR_W  beat word address.
- mem_wdata  out  DATA_W  writeback beat data.
- mem_ack  in  1  beat completes this cycle; on a refill beat, mem_rdata is valid.
- mem_rdata  in  DATA_W  refill data.

Behaviour:
- Address split, LSB first: 2 byte bits | log2(LINE_WORDS) word bits | log2(SETS) index bits | tag in the remaining bits.
- Storage per set:
  - valid, dirty, tag.
  - LINE_WORDS data words, held in registers.
  - Reads are asynchronous.
- Hit condition: valid[idx] & tag[idx] == req tag.
- FSM states:
  - IDLE:
    - req_valid & hit: dcache_stall = 0.
    - Load hit: rdata = word[idx][woff], same cycle.
    - Store hit: strobed bytes updated at the clk edge; dirty[idx] set.
    - req_valid & !hit: dcache_stall = 1, same cycle (combinational). If the victim is valid & dirty, go to WB; otherwise go to REFILL. Beat counter cleared.
  - WB:
    - mem_req = 1, mem_we = 1.
    - mem_addr = {victim tag, idx, beat, 2'b00}; mem_wdata = word[idx][beat].
    - On mem_ack: beat increments. After the last beat (beat == LINE_WORDS-1 & ack), go to REFILL with beat = 0.
  - REFILL:
    - mem_req = 1, mem_we = 0.
    - mem_addr = {req tag, idx, beat, 2'b00}.
    - On mem_ack: word[idx][beat] = mem_rdata.
    - On the last ack: tag[idx] = req tag, valid = 1, dirty = 0; go to IDLE.
- Request re-evaluation: in the cycle after returning to IDLE, the held request re-evaluates and hits. dcache_stall drops then.
- Total miss penalty with zero-wait memory:
  - clean victim: LINE_WORDS+1 cycles stalled;
  - dirty victim: 2·LINE_WORDS+1 cycles.
- Stall rules:
  - dcache_stall = 1 in every cycle where state != IDLE.
  - dcache_stall = 0 when req_valid = 0 in IDLE.
- Memory beat ordering:
  - Beats are ascending, from word 0 to LINE_WORDS-1.
  - While mem_req = 1 and mem_ack = 0, mem_addr, mem_we and mem_wdata hold stable.
  - mem_req is deasserted in IDLE.
  - mem_ack while mem_req = 0 is ignored.
- Request capture: req_addr, req_we, req_wdata and req_wstrb are guaranteed stable while dcache_stall = 1, because the pipeline is frozen. The FSM uses the live inputs.
- Store with req_wstrb = 0 that hits: no byte changes; dirty still set.
- Repeated stores under external stall: a store hit repeated on consecutive cycles (pipeline held by the other cache's stall) rewrites the same bytes. This is idempotent and required to be harmless.
- Reset (any state, including mid-beat):
  - Next cycle: state IDLE, beat = 0, all valid = 0, all dirty = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - dcache_stall = 0 while rst is high.
  - rdata = 0 while rst is high, which overrides the hit mux.
  - Data arrays are not cleared.
  - Partially refilled lines remain invalid.

Test Plan:
- Cold load miss:
  - Stimulus: after reset, load 0x100; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 with immediate ack.
  - Required: stall=1 from the first cycle; mem_addr sequence 0x100, 0x104, 0x108, 0x10C, mem_we=0; stall=0 on cycle 5; rdata=0x11111111.
- Load hit:
  - Stimulus: load 0x108 next.
  - Required: stall=0, rdata=0x33333333 the same cycle, mem_req stays 0.
- Store hit with strobe:
  - Stimulus: store 0x108, wdata=0xAAAABBBB, wstrb=4'b0011.
  - Required: no memory traffic; a subsequent load of 0x108 returns 0x3333BBBB.
- Dirty conflict miss:
  - Stimulus: load 0x500 (same index, different tag).
  - Required: 4 writeback beats at 0x100–0x10C with mem_we=1 and data 0x11111111, 0x22222222, 0x3333BBBB, 0x44444444; then 4 refill beats at 0x500–0x50C; stall held for 9 cycles.
- Slow memory:
  - Stimulus: mem_ack is delayed 3 cycles on every beat.
  - Required: mem_req, mem_addr and mem_wdata are unchanged during the wait cycles; stall is held continuously; beat count is correct.
- Reset mid-refill:
  - Stimulus: rst is asserted after the 2nd refill ack for 0x200.
  - Required: the next cycle shows mem_req=0, stall=0, state IDLE; a later load of 0x200 misses again and issues 4 beats from 0x200.
